// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state encoding and one-hot helper for decoder_onehot_pipe
package decoder_pkg;

    typedef enum logic [1:0] {
        DEC_IDLE = 2'd0,
        DEC_HOLD = 2'd1,
        DEC_SCAN = 2'd2
    } dec_state_e;

    localparam int DEC_MAX_IN_W  = 8;
    localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_IN_W;

    // Callers size-cast the argument up from IN_W and the result down to OUT_W.
    function automatic logic [DEC_MAX_OUT_W-1:0] onehot_of(input logic [DEC_MAX_IN_W-1:0] idx);
        logic [DEC_MAX_OUT_W-1:0] w;
        w      = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/dec_scan_ctr.sv
// rtl/dec_scan_ctr.sv - scan index and sweep counters with last-step flag
module dec_scan_ctr #(
    parameter int IN_W        = 3,
    parameter int SCAN_SWEEPS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic step,
    output logic last_step
);

    localparam int SW_W = (SCAN_SWEEPS > 1) ? $clog2(SCAN_SWEEPS) : 1;
    localparam logic [IN_W-1:0] IDX_MAX   = '1;
    localparam logic [SW_W-1:0] SWEEP_MAX = SW_W'(SCAN_SWEEPS - 1);

    logic [IN_W-1:0] idx;
    logic [SW_W-1:0] sweep;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx   <= '0;
            sweep <= '0;
        end else if (step) begin
            idx <= idx + 1'b1;
            if (idx == IDX_MAX && sweep != SWEEP_MAX)
                sweep <= sweep + 1'b1;
        end
    end

    assign last_step = (idx == IDX_MAX) && (sweep == SWEEP_MAX);

endmodule

// File: rtl/decoder_onehot_pipe.sv
// rtl/decoder_onehot_pipe.sv - registered one-hot decoder with handshakes; scan mode under DEC_SCAN_EN
module decoder_onehot_pipe
    import decoder_pkg::*;
#(
    parameter int IN_W        = 3,
    parameter int SCAN_SWEEPS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_sel,
    input  logic                   scan_start,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [(1<<IN_W)-1:0]   out,
    output logic                   busy
);

    localparam int OUT_W = 1 << IN_W;

    dec_state_e       state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             accept, scan_go, last_step;

    assign in_ready = en && !rst && (state_q != DEC_SCAN) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef DEC_SCAN_EN
    assign scan_go = scan_start && in_ready && !in_valid;
    assign busy    = (state_q == DEC_SCAN);

    dec_scan_ctr #(
        .IN_W        (IN_W),
        .SCAN_SWEEPS (SCAN_SWEEPS)
    ) u_scan_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear     (scan_go),
        .step      (en && out_ready && state_q == DEC_SCAN),
        .last_step (last_step)
    );
`else
    logic unused_scan_start;
    assign unused_scan_start = scan_start;
    assign scan_go           = 1'b0;
    assign last_step         = 1'b0;
    assign busy              = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        if (!en) begin
            state_d = DEC_IDLE;
            out_d   = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            state_d = DEC_HOLD;
            out_d   = OUT_W'(onehot_of(DEC_MAX_IN_W'(in_sel)));
            valid_d = 1'b1;
        end else if (scan_go) begin
            state_d = DEC_SCAN;
            out_d   = OUT_W'(1);
            valid_d = 1'b1;
        end else begin
            case (state_q)
                DEC_HOLD: if (out_ready) begin
                    state_d = DEC_IDLE;
                    out_d   = '0;
                    valid_d = 1'b0;
                end
                DEC_SCAN: if (out_ready) begin
                    if (last_step) begin
                        state_d = DEC_IDLE;
                        out_d   = '0;
                        valid_d = 1'b0;
                    end else begin
                        // rotating wraps 0x80 back to 0x01 at each sweep boundary
                        out_d = {out_q[OUT_W-2:0], out_q[OUT_W-1]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DEC_IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule
